// File: rtl/uart_console.sv
// uart_console: Wishbone-attached transmit-only UART with a TX FIFO.
//
// Ports:
//   wb_clk    - single clock, all logic on the rising edge
//   wb_rst    - synchronous active-high reset
//   wb_cyc    - Wishbone cycle
//   wb_stb    - Wishbone strobe
//   wb_we     - 1 = write, 0 = read
//   wb_adr    - address; only [3:2] decoded (0 = TXDATA, 1 = STATUS, 2..3 reserved)
//   wb_dat_o  - write data from the master
//   wb_dat_i  - registered read data to the master
//   wb_ack    - registered one-cycle transfer acknowledge
//   tx        - serial line, idle high
//
// STATUS layout: {16'h0, count[7:0], 4'h0, ovf, busy, full, empty}.
module uart_console #(
  parameter int unsigned FREQUENCY  = 25000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_o,
  output logic [31:0] wb_dat_i,
  output logic        wb_ack,
  output logic        tx
);

  localparam int unsigned DIV = FREQUENCY / BAUD_RATE;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_cnt;
  logic                 ovf;

  logic                 req, push, pop, full, empty, busy, baud_end, last_stop;
  logic [8:0]           count9;
  logic [31:0]          status;
  logic [DATA_BITS-1:0] head;
  logic                 unused_bits;

  always_comb begin
    req       = wb_cyc & wb_stb & ~wb_ack;
    full      = (count == (AW+1)'(FIFO_DEPTH));
    empty     = (count == '0);
    busy      = (state != IDLE);
    // Fullness is judged before the edge, so a pop on the same edge cannot make room.
    push      = req & wb_we & (wb_adr[3:2] == 2'd0) & ~full;
    baud_end  = (baud_cnt == DIV_LAST);
    last_stop = (state == STOP) & baud_end & (bit_cnt == 3'(STOP_BITS - 1));
    pop       = ~empty & ((state == IDLE) | last_stop);
    // A full 256-deep FIFO reports count 8'h00; bit 8 is dropped.
    count9    = 9'(count);
    status    = {16'h0, count9[7:0], 4'h0, ovf, busy, full, empty};
    head      = mem[rd_ptr];
    unused_bits = ^{wb_adr[31:4], wb_adr[1:0], wb_dat_o, count9[8]};
  end

  always_ff @(posedge wb_clk) begin
    if (push) mem[wr_ptr] <= wb_dat_o[DATA_BITS-1:0];
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb_ack   <= 1'b0;
      wb_dat_i <= '0;
      ovf      <= 1'b0;
    end else begin
      wb_ack   <= 1'b0;
      wb_dat_i <= '0;
      if (req) begin
        wb_ack <= 1'b1;
        if (wb_we) begin
          if (wb_adr[3:2] == 2'd0 && full) ovf <= 1'b1;
          if (wb_adr[3:2] == 2'd1 && wb_dat_o[3]) ovf <= 1'b0;
        end else if (wb_adr[3:2] == 2'd1) begin
          wb_dat_i <= status;
        end
      end
    end
  end

  // tx is registered from the current state, so the line lags the state by one
  // clock; every bit still lasts exactly DIV clocks and frames chain seamlessly.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      if (pop) begin
        shreg   <= head;
        par_bit <= (PARITY == 2) ? ~(^head) : (^head);
      end
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (pop) state <= START;
        end
        START: begin
          tx <= 1'b0;
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          tx <= shreg[0];
          if (baud_end) begin
            baud_cnt <= '0;
            shreg    <= shreg >> 1;
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PAR: begin
          tx <= par_bit;
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= pop ? START : IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_console.sv
// tb_uart_console: randomized scoreboard bench for uart_console.
// Runs a 7-bit, odd-parity, 2-stop-bit configuration with a 4-deep FIFO and DIV=16.
module tb_uart_console;

  localparam int unsigned DIV   = 16;
  localparam int unsigned DB    = 7;
  localparam int unsigned PAR   = 2;
  localparam int unsigned SB    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NB    = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
  localparam int          F     = NB * DIV;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we, ack, tx;
  logic [31:0] adr, wdat, rdat;

  int edge_n = 0;
  int total = 0, bad = 0;

  typedef struct { logic [15:0] bits; int start; } frame_t;
  typedef struct { int a; int p; } hist_t;
  frame_t exp_q[$];
  hist_t  hist[$];
  int     last_p;
  bit     m_ovf;
  bit     mon_in = 1'b0;

  uart_console #(
    .FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(DB),
    .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .wb_clk(clk), .wb_rst(rst), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
    .wb_adr(adr), .wb_dat_o(wdat), .wb_dat_i(rdat), .wb_ack(ack), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes accepted before edge e that are still unpopped when e arrives.
  function automatic int count_before(input int e);
    int c = 0;
    foreach (hist[i]) if (hist[i].a < e && hist[i].p >= e) c++;
    return c;
  endfunction

  // Transmitter is busy from its pop edge for F clocks.
  function automatic bit busy_before(input int e);
    foreach (hist[i]) if (hist[i].p < e && e <= hist[i].p + F) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_status(input int e);
    int c = count_before(e);
    return {16'h0, 8'(c), 4'h0, m_ovf, busy_before(e), c == DEPTH, c == 0};
  endfunction

  function automatic logic [15:0] frame_bits(input logic [31:0] d);
    logic [15:0] b = '0;
    int ones = 0;
    for (int i = 0; i < DB; i++) begin
      b[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (PAR != 0) b[1+DB] = (PAR == 1) ? ones[0] : ~ones[0];
    for (int i = 0; i < SB; i++) b[NB-SB+i] = 1'b1;
    return b;
  endfunction

  task automatic model_write(input int e, input logic [31:0] d);
    int p;
    if (count_before(e) == DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      p = (e + 1 > last_p + F) ? e + 1 : last_p + F;
      hist.push_back('{a: e, p: p});
      last_p = p;
      exp_q.push_back('{bits: frame_bits(d), start: p + 1});
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    last_p = -100000;
    m_ovf  = 1'b0;
  endtask

  // ---------------- bus tasks ----------------
  task automatic wb_op(input bit w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r, output int e);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; e = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin e = edge_n; break; end
    end
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (e < 0) begin
      total++; bad++;
      $display("FAIL ack_timeout: got no ack expected ack within 8 cycles");
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int e;
    wb_op(1'b1, a, d, r, e);
    if (e >= 0) begin
      if (a[3:2] == 2'd0) model_write(e, d);
      if (a[3:2] == 2'd1 && d[3]) m_ovf = 1'b0;
    end
  endtask

  task automatic rd(input logic [31:0] a, input string name);
    logic [31:0] r;
    int e;
    wb_op(1'b0, a, '0, r, e);
    if (e >= 0) check(name, r, (a[3:2] == 2'd1) ? model_status(e) : 32'h0);
  endtask

  task automatic burst6();
    logic [31:0] bd [6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    int e, prev = -1;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; wdat = bd[0];
    for (int i = 0; i < 6; i++) begin
      e = -1;
      for (int j = 0; j < 8; j++) begin
        @(posedge clk); #1;
        if (ack) begin e = edge_n; break; end
      end
      if (e < 0) begin
        total++; bad++;
        $display("FAIL burst_ack_timeout: got no ack expected ack for write %0d", i);
        break;
      end
      model_write(e, bd[i]);
      if (i > 0) check("ack_alternate", 32'(e - prev), 32'd2);
      prev = e;
      if (i < 5) wdat = bd[i+1];
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_single_cycle", 32'(ack), 32'd0);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !mon_in && edge_n > last_p + F) begin done = 1'b1; break; end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d frames pending expected 0", exp_q.size());
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    int s, off, k;
    logic [15:0] got;
    frame_t f;
    bit have_f;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mon_in = 1'b0;
      end else if (!mon_in) begin
        if (tx === 1'b0) begin
          mon_in = 1'b1;
          s = edge_n;
          got = '0;
          if (exp_q.size() == 0) begin
            have_f = 1'b0;
            total++; bad++;
            $display("FAIL unexpected_frame: got start bit at edge %0d expected none", s);
          end else begin
            f = exp_q.pop_front();
            have_f = 1'b1;
            check("start_edge", 32'(s), 32'(f.start));
          end
        end
      end else begin
        off = edge_n - s;
        if (off % DIV == DIV / 2) begin
          k = off / DIV;
          got[k] = tx;
          if (k == NB - 1) begin
            mon_in = 1'b0;
            if (have_f) check("frame_bits", 32'(got), 32'(f.bits));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] fb;
    int s0, target, op;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_dat", rdat, 32'h0);
    rst = 1'b0;
    rd(32'h4, "status_reset");

    wr(32'h0, 32'h03);
    rd(32'h4, "status_busy");
    wait_idle();
    rd(32'h4, "status_idle");

    wr(32'h0, 32'hA5);
    wr(32'h0, 32'h3C);
    wait_idle();

    burst6();
    rd(32'h4, "status_ovf");
    wr(32'h4, 32'h8);
    rd(32'h4, "status_ovf_clear");
    wait_idle();

    wr(32'h0, 32'h01);
    wr(32'h0, 32'h02);
    wr(32'h0, 32'h03);
    rd(32'h4, "status_count");
    wait_idle();

    rd(32'h0, "txdata_read");
    rd(32'h8, "reserved_read");
    wr(32'hC, 32'hFF);
    rd(32'h4, "status_after_reserved");

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 5)      wr(32'h0, $urandom);
      else if (op == 6) rd(32'h4, "status_rand");
      else if (op == 7) wr(32'h4, $urandom);
      else if (op == 8) rd({28'h0, 2'($urandom_range(0, 3)) & 2'b10 | 2'b00, 2'b00}, "zero_read_rand");
      else              wr(32'h8 | ($urandom_range(0, 1) << 2), $urandom);
      repeat ($urandom_range(0, 120)) @(posedge clk);
    end
    wait_idle();
    rd(32'h4, "status_rand_end");

    wr(32'h0, 32'h77);
    s0 = hist[hist.size()-1].p + 1;
    wr(32'h0, 32'h11);
    wr(32'h0, 32'h22);
    target = s0 + 4 * DIV + 4;
    for (int i = 0; i < 2000 && edge_n < target; i++) @(posedge clk);
    @(negedge clk);
    fb = frame_bits(32'h77);
    check("tx_bit3_before_reset", 32'(tx), 32'(fb[4]));
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("reset_mid_tx", 32'(tx), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    rd(32'h4, "status_after_reset");
    repeat (3 * F) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_console.md
UART_CONSOLE -- requirements
Module: uart_console

Parameters
REQ-001 SHALL have parameter FREQUENCY, default 25000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..8, data bits per frame.
REQ-004 SHALL have parameter PARITY, default 0, 0=none 1=even 2=odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1..2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, power of two 2..256, TX FIFO entries.

Interface
REQ-007 SHALL have wb.clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have wb.rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have wb.CYC and wb.STB, input, 1 each, Wishbone cycle and strobe.
REQ-010 SHALL have wb.WE, input, 1, 1=write 0=read.
REQ-011 SHALL have wb.ADR, input, 32; only ADR[3:2] is decoded: 0=TXDATA, 1=STATUS, 2..3 reserved.
REQ-012 SHALL have wb.DAT_O, input, 32, write data from master.
REQ-013 SHALL have wb.DAT_I, output, 32, read data to master.
REQ-014 SHALL have wb.ACK, output, 1, registered transfer acknowledge.
REQ-015 SHALL have tx, output, 1, serial line, idle high.

Function
REQ-016 SHALL assert ACK for exactly one cycle, on the edge after CYC&STB is sampled with ACK low; back-to-back requests are acknowledged on alternate cycles.
REQ-017 SHALL perform each register side effect once per ACK, on the edge that raises ACK.
REQ-018 TXDATA write SHALL push DAT_O[DATA_BITS-1:0] when the FIFO is not full, evaluated before that edge.
REQ-019 TXDATA write while full SHALL still ACK, SHALL drop the byte, and SHALL set sticky OVF; a same-cycle pop does not rescue it.
REQ-020 STATUS read SHALL return {16'h0, count[7:0], 4'h0, OVF, busy, full, empty}, bits 3:0 = OVF, busy, full, empty from MSB down; count=FIFO_DEPTH SHALL read 8'h00 when FIFO_DEPTH=256, with full=1.
REQ-021 STATUS write with DAT_O[3]=1 SHALL clear OVF; other bits are read-only.
REQ-022 TXDATA read and reserved addresses SHALL return 0 and SHALL have no side effect; reserved writes are ignored but acknowledged.
REQ-023 DIV SHALL equal FREQUENCY/BAUD_RATE, integer-truncated; every bit period lasts exactly DIV clocks.
REQ-024 SHALL implement FSM IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE, or -> START directly if the FIFO is non-empty at the end of STOP.
REQ-025 In IDLE with the FIFO non-empty, SHALL pop the head and enter START on the next edge; tx=0 SHALL appear 2 cycles after the ACK cycle of a write to an empty FIFO while idle.
REQ-026 DATA SHALL send DATA_BITS bits LSB first; PARITY SHALL send the XOR of the data bits (even) or its inverse (odd); STOP SHALL hold tx=1 for STOP_BITS*DIV clocks.
REQ-027 busy SHALL be 1 in every state other than IDLE.
REQ-028 Simultaneous push and pop SHALL leave count unchanged; read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-029 On wb.rst SHALL set tx=1, ACK=0, DAT_I=0, FSM=IDLE, pointers and count=0, OVF=0, and all bit and baud counters to 0.
REQ-030 Reset asserted mid-frame SHALL drive tx=1 on the next edge and SHALL discard the frame and all queued data.

Verification
Use FREQUENCY=16, BAUD_RATE=1 (DIV=16) unless stated.
REQ-031 Single write: write TXDATA=0x55 with defaults -> ACK 1 cycle; tx low 2 cycles later for 16 clocks; bits 1,0,1,0,1,0,1,0 at 16 clocks each; stop high 16 clocks; busy then returns 0.
REQ-032 Overflow: FIFO_DEPTH=4, write 6 bytes back-to-back while the line is busy -> 6 ACKs; 4 bytes queued (5 sent in total including the one already popped); STATUS shows OVF=1; writing STATUS=0x8 clears OVF.
REQ-033 Parity and stop: DATA_BITS=7, PARITY=2, STOP_BITS=2, write 0x03 -> start, 1100000, parity bit 1, two stop bits, total frame 11*16 clocks.
REQ-034 Back-to-back: queue 0xA5 and 0x3C -> second start bit immediately follows the first frame's stop bit, with no idle cycle.
REQ-035 Reset mid-frame: assert wb.rst during bit 3 of 0xFF with 2 bytes queued -> tx=1 the next cycle; STATUS reads 0x00000001 afterwards; no further frames are sent.
REQ-036 Status count: with DIV large, write 3 bytes -> STATUS count field reads 2 after the first pop, and empty=0, full=0.
